// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the round-robin sequence scheduler.
package seq_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam logic [31:0] SEED = 32'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_core.sv
// Term generator: t(n) = t(n-3) + t(n-2), seeded 1,1,1; reseeds on clr, advances on step.
module seq_core
  import seq_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        step,
  output logic [31:0] term
);

  logic [31:0] t0;
  logic [31:0] t1;
  logic [31:0] t2;

  // t0 is the term on offer; t1/t2 are the next two. The sum wraps modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t0 <= SEED;
      t1 <= SEED;
      t2 <= SEED;
    end else if (clr) begin
      t0 <= SEED;
      t1 <= SEED;
      t2 <= SEED;
    end else if (step) begin
      t0 <= t1;
      t1 <= t2;
      t2 <= t0 + t1;
    end
  end

  assign term = t0;

endmodule

// File: rtl/seq_sched.sv
// Shares one seq_core among NUM_REQ requesters; round-robin grant, one burst at a time.
module seq_sched
  import seq_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*CNT_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_last,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              found;
  logic [ID_W-1:0]   win;
  logic [CNT_W-1:0]  win_len;
  int                idx;
  logic              last_beat;
  logic              core_clr;
  logic              core_step;
  logic [31:0]       term;

  // Search starts at the pointer and wraps, so the first asserted bit found wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_len = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) win_len = req_len[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = GRANT;
      GRANT:   state_d = (found && (win_len != '0)) ? RUN : IDLE;
      RUN:     if (out_ready && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == GRANT) && found && (win == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == GRANT && found) begin
        len_q <= win_len;
        id_q  <= win;
        cnt_q <= '0;
        ptr_q <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      end else if (state_q == RUN && out_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // len_q is never zero in RUN, so len_q-1 is the index of the final beat.
  assign last_beat = (cnt_q == len_q - 1'b1);
  assign core_clr  = (state_q == GRANT);
  assign core_step = out_valid && out_ready;

  seq_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr),
    .step  (core_step),
    .term  (term)
  );

  assign out_valid = (state_q == RUN);
  assign out_data  = out_valid ? term : '0;
  assign out_id    = id_q;
  assign out_last  = out_valid && last_beat;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_sched.sv
// Randomized scoreboard bench for seq_sched: grants checked against a round-robin model, beats against a queue.
module tb_seq_sched;
  import seq_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_len = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [31:0]    out_data;
  logic [1:0]     out_id;
  logic           out_last;
  logic           busy;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int ptr_m = 0;
  int ready_mode = 0;
  int ready_phase = 0;
  int beats_seen = 0;

  seq_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence straight from the recurrence, wrapping naturally in 32 bits.
  task automatic push_burst(input int id, input int len);
    logic [31:0] t[$];
    beat_t b;
    for (int n = 0; n < len; n++) begin
      if (n < 3) t.push_back(32'd1);
      else t.push_back(t[n-3] + t[n-2]);
      b.data = t[n];
      b.id   = 2'(id);
      b.last = (n == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // out_ready modes: 0 always high, 1 random, 2 pattern 1,0,0 repeating.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (ready_phase % 3 == 0);
          ready_phase++;
        end
      endcase
    end
  end

  // Monitor: pops on every transfer and checks stability across stalls.
  logic        stall_prev = 1'b0;
  logic [31:0] hold_data;
  logic [1:0]  hold_id;
  logic        hold_last;
  beat_t       e;

  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_output("stall_valid", 32'(out_valid), 32'd1);
        check_output("stall_data", out_data, hold_data);
        check_output("stall_id", 32'(out_id), 32'(hold_id));
        check_output("stall_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h id %0d, expected no beat", out_data, out_id);
        end else begin
          e = exp_q.pop_front();
          check_output("beat_data", out_data, e.data);
          check_output("beat_id", 32'(out_id), 32'(e.id));
          check_output("beat_last", 32'(out_last), 32'(e.last));
        end
        beats_seen++;
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
      hold_id    = out_id;
      hold_last  = out_last;
    end
  end

  task automatic check_reset_outputs();
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_id", 32'(out_id), 32'd0);
    check_output("rst_out_last", 32'(out_last), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    ptr_m = 0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_grant(input logic [N-1:0] pending_in, input int lens[N], output int w);
    int guard;
    guard = 0;
    w = -1;
    while (w < 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) begin
          if (w < 0 && pending_in[(ptr_m + i) % N]) w = (ptr_m + i) % N;
        end
        check_output("grant_onehot", 32'(req_ready), 32'(1 << w));
        check_output("grant_no_valid", 32'(out_valid), 32'd0);
        check_output("grant_busy", 32'(busy), 32'd1);
        push_burst(w, lens[w]);
        ptr_m = (w + 1) % N;
      end
    end
    if (w < 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL grant_timeout: got no req_ready, expected a grant");
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] mask, input int lens[N]);
    logic [N-1:0] pending;
    int w;
    int guard;
    pending = mask;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_len[i*W +: W] = W'(lens[i]);
    req_valid = mask;
    while (pending != '0) begin
      wait_grant(pending, lens, w);
      if (w < 0) begin
        req_valid = '0;
        break;
      end
      pending[w] = 1'b0;
      @(posedge clk); #1;
      req_valid[w] = 1'b0;
      @(negedge clk);
      check_output("valid_after_grant", 32'(out_valid), 32'(lens[w] != 0));
      check_output("ready_pulse_width", 32'(req_ready), 32'd0);
    end
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 5000) begin
      n_fail++;
      $display("[TB] FAIL burst_drain: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int lens[N];
    int w;
    int base;
    int guard;
    logic [N-1:0] mask;

    #1 reset = 1'b0;
    #3 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] single requester, len 9");
    ready_mode = 0;
    lens = '{9, 0, 0, 0};
    apply_stimulus(4'b0001, lens);

    $display("[TB] all four requesters, len 2, round-robin");
    apply_reset();
    lens = '{2, 2, 2, 2};
    apply_stimulus(4'b1111, lens);
    apply_stimulus(4'b0001, lens);

    $display("[TB] len 5 with stalling out_ready");
    ready_phase = 0;
    ready_mode = 2;
    lens = '{5, 0, 0, 0};
    apply_stimulus(4'b0001, lens);

    $display("[TB] zero-length grant then len 3");
    ready_mode = 0;
    lens = '{0, 0, 3, 0};
    apply_stimulus(4'b0110, lens);
    lens = '{2, 0, 0, 2};
    apply_stimulus(4'b1001, lens);

    $display("[TB] long bursts, random out_ready");
    ready_mode = 1;
    lens = '{0, 0, 200, 0};
    apply_stimulus(4'b0100, lens);
    lens = '{0, 0, 0, 255};
    apply_stimulus(4'b1000, lens);

    $display("[TB] random rounds");
    for (int r = 0; r < 20; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) lens[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      apply_stimulus(mask, lens);
    end

    $display("[TB] reset mid-burst");
    ready_mode = 0;
    lens = '{9, 0, 0, 0};
    @(posedge clk); #1;
    req_len[0 +: W] = 8'd9;
    req_valid = 4'b0001;
    wait_grant(4'b0001, lens, w);
    @(posedge clk); #1;
    req_valid = '0;
    base = beats_seen;
    guard = 0;
    while (beats_seen < base + 4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #2 reset = 1'b0;
    exp_q.delete();
    ptr_m = 0;
    #1 check_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      check_output("held_in_reset", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    lens = '{3, 0, 0, 0};
    apply_stimulus(4'b0001, lens);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_sched.md
SEQ_SCHED -- requirements
Module: seq_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the generator.
REQ-002 SHALL have parameter CNT_W, default 8, width of the burst-length field.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester burst request.
REQ-006 SHALL have port req_len  input  NUM_REQ x CNT_W  per-requester term count; held while req_valid is high.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot grant/accept pulse.
REQ-008 SHALL have port out_valid  output  1  term available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts term.
REQ-010 SHALL have port out_data  output  32  sequence term.
REQ-011 SHALL have port out_id  output  clog2(NUM_REQ)  owner of the current term.
REQ-012 SHALL have port out_last  output  1  final term of the burst.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-014 SHALL time-share one generator: terms t0=t1=t2=1, tn = t(n-3) + t(n-2), i.e. 1,1,1,2,2,3,4,5,7,9,12,...; addition modulo 2^32, carry discarded.
REQ-015 SHALL restart the generator from t0 at the start of every granted burst; no state carries over between bursts.
REQ-016 SHALL implement FSM states IDLE, GRANT and RUN.
- IDLE -> GRANT when any req_valid is high.
- GRANT -> RUN when the granted length is non-zero; GRANT -> IDLE when it is zero.
- RUN -> IDLE on the handshake of the out_last term.
REQ-017 SHALL, in GRANT, assert exactly one req_ready bit for exactly one cycle: the winner chosen by round-robin from the priority pointer among the asserted req_valid bits.
REQ-018 SHALL capture req_len and the winner id in the GRANT cycle; the request counts as accepted in that cycle.
REQ-019 SHALL advance the round-robin pointer to (winner+1) mod NUM_REQ on every grant, including zero-length grants.
REQ-020 SHALL complete a zero-length request with no output beats.
REQ-021 SHALL assert out_valid in the cycle after GRANT and produce the first term then; a term transfers when out_valid and out_ready are both high.
REQ-022 SHALL hold out_data, out_id and out_last stable while out_valid is high and out_ready is low.
REQ-023 SHALL step the generator only on a transfer, giving one term per cycle when out_ready is held high.
REQ-024 SHALL assert out_last only with the req_len-th term; a length of 2^CNT_W-1 SHALL yield exactly that many terms.
REQ-025 SHALL not grant a new request until the current burst completes; req_valid changes during RUN SHALL be ignored.
REQ-026 SHALL return to IDLE for one cycle between bursts, so back-to-back bursts have a one-cycle IDLE gap plus a one-cycle GRANT gap.
REQ-027 SHALL keep out_valid low in IDLE and GRANT.

Reset
REQ-028 SHALL, while reset is low, asynchronously force: state IDLE; pointer 0; generator seeds 1,1,1; req_ready 0; out_valid 0; out_data 0; out_id 0; out_last 0; busy 0.
REQ-029 SHALL abandon any in-flight burst on reset with no further beats; after reset release the first grant SHALL start a fresh burst from t0.

Structure
REQ-030 SHALL place NUM_REQ and CNT_W defaults, the IDLE/GRANT/RUN state enum and the SEED constant (32'd1) in package seq_sched_pkg.
REQ-031 SHALL instantiate sub-module seq_core, which contains the three 32-bit term registers and the adder and has ports clr (reseed) and step (advance), and which presents the current term.

Verification
REQ-032 SHALL cover: req0 only, len=9, out_ready=1 -> out_data 1,1,1,2,2,3,4,5,7 on consecutive cycles, out_last on the 7, out_id=0.
REQ-033 SHALL cover: all four requesting with len=2 -> grant order 0,1,2,3,0; each burst is 1,1.
REQ-034 SHALL cover: len=5, out_ready toggling 1,0,0,1,... -> out_data held through stalls; the sequence is still 1,1,1,2,2.
REQ-035 SHALL cover: req1 len=0 and req2 len=3, pointer at 1 -> req1 gets a pulse with no beats, then req2 is served, and the pointer ends at 3.
REQ-036 SHALL cover: len=200 -> wrap-around check of tn against a modulo-2^32 model; out_last on beat 200.
REQ-037 SHALL cover: reset asserted mid-burst at beat 4 -> all outputs 0 asynchronously; the next burst starts at 1,1,1.
